// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 frames use odd parity over the 8 data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows
// the synchronised line after it has held a new level for FILTER_LEN cycles.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the 2-FF chain work.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 receiver: frames bytes off the filtered lines, then tracks the most
// recently pressed key that is still held, handling F0 (break) and E0 (extended).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] curPressed,
  output logic       keyValid,
  output logic       frameErr
);

  logic clk_f;
  logic data_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .resetN (resetN),
    .line_i (ps2Clk),
    .line_o (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .resetN (resetN),
    .line_i (ps2Data),
    .line_o (data_f)
  );

  ps2_state_t  state_q, state_d;
  logic        clk_f_prev_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic [7:0]  cur_q, cur_d;
  logic        kv_q, kv_d;
  logic        fe_q, fe_d;
  logic        fall;
  logic        timeout;

  assign fall    = clk_f_prev_q & ~clk_f;
  assign timeout = (state_q != IDLE) && !fall && (idle_cnt_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      clk_f_prev_q <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      idle_cnt_q   <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      cur_q        <= '0;
      kv_q         <= 1'b0;
      fe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_f_prev_q <= clk_f;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      idle_cnt_q   <= idle_cnt_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      cur_q        <= cur_d;
      kv_q         <= kv_d;
      fe_q         <= fe_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    cur_d      = cur_q;
    kv_d       = 1'b0;
    fe_d       = 1'b0;
    idle_cnt_d = (state_q == IDLE || fall) ? 16'd0 : idle_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (fall && !data_f) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = data_f;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_f && parity_ok(shift_q, par_q)) begin
            if (shift_q == PS2_BREAK) begin
              brk_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              // Extended keys are dropped; a release only clears the key it names.
              if (ext_q) begin
                cur_d = cur_q;
              end else if (brk_q) begin
                if (shift_q == cur_q) cur_d = 8'h00;
              end else begin
                cur_d = shift_q;
                kv_d  = 1'b1;
              end
            end
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d    = IDLE;
      fe_d       = 1'b1;
      brk_d      = 1'b0;
      ext_d      = 1'b0;
      idle_cnt_d = 16'd0;
    end
  end

  assign curPressed = cur_q;
  assign keyValid   = kv_q;
  assign frameErr   = fe_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed PS/2 scenarios plus random
// byte streams, compared against a key-tracking model of the keyboard protocol.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 50000;
  localparam int HALF       = 15;
  localparam int SETTLE     = 30;

  logic       clk = 1'b0;
  logic       resetN;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] curPressed;
  logic       keyValid;
  logic       frameErr;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .curPressed (curPressed),
    .keyValid   (keyValid),
    .frameErr   (frameErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int fe_cycle = 0;
  int t_fall   = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (keyValid) kv_cnt <= kv_cnt + 1;
    if (frameErr) begin
      fe_cnt   <= fe_cnt + 1;
      fe_cycle <= cyc;
    end
    if (keyValid && frameErr) both_cnt <= both_cnt + 1;
  end

  // Model: which key the keyboard says is newest and still held.
  logic [7:0] m_cur = 8'h00;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[i];
      wait_clk(HALF);
      ps2Clk = 1'b0;
      t_fall = cyc;
      wait_clk(HALF);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad, output int exp_kv, output int exp_fe);
    exp_kv = 0;
    exp_fe = 0;
    if (bad) begin
      exp_fe = 1;
      m_brk  = 1'b0;
      m_ext  = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (!m_ext) begin
        if (!m_brk) begin
          m_cur  = b;
          exp_kv = 1;
        end else if (m_cur == b) begin
          m_cur = 8'h00;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic frame_and_check(input logic [7:0] b, input bit bad, input string tag);
    int kv0, fe0, exp_kv, exp_fe;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(b, bad, 11);
    wait_clk(SETTLE);
    model_byte(b, bad, exp_kv, exp_fe);
    check({tag, "/cur"}, curPressed, m_cur);
    check({tag, "/keyValid"}, kv_cnt - kv0, exp_kv);
    check({tag, "/frameErr"}, fe_cnt - fe0, exp_fe);
  endtask

  logic [7:0] pool [8] = '{8'h1C, 8'h1D, 8'h23, 8'h24, 8'hF0, 8'hF0, 8'hE0, 8'h75};

  initial begin
    int kv0, fe0, lat;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    resetN  = 1'b0;
    wait_clk(5);
    check("reset/cur", curPressed, 8'h00);
    check("reset/keyValid", keyValid, 1'b0);
    check("reset/frameErr", frameErr, 1'b0);
    resetN = 1'b1;
    wait_clk(20);

    frame_and_check(8'h1D, 1'b0, "press_1D");
    frame_and_check(8'hF0, 1'b0, "brk");
    frame_and_check(8'h1D, 1'b0, "release_1D");

    frame_and_check(8'h1D, 1'b0, "press_1D_again");
    frame_and_check(8'h23, 1'b0, "press_23");
    frame_and_check(8'hF0, 1'b0, "brk2");
    frame_and_check(8'h1D, 1'b0, "release_other");
    frame_and_check(8'h23, 1'b0, "typematic_23");

    frame_and_check(8'hE0, 1'b0, "ext");
    frame_and_check(8'h75, 1'b0, "ext_up");
    frame_and_check(8'h43, 1'b0, "press_43");

    // Pending E0 must be dropped by the parity error, or 4B would be discarded.
    frame_and_check(8'hE0, 1'b0, "ext_before_err");
    frame_and_check(8'h1D, 1'b1, "bad_parity");
    frame_and_check(8'h4B, 1'b0, "after_err_4B");

    // Pending F0 must be dropped by the timeout, or 2D would be treated as a release.
    frame_and_check(8'hF0, 1'b0, "brk_before_timeout");
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h2D, 1'b0, 5);
    for (int i = 0; i < TIMEOUT + 10000 && fe_cnt == fe0; i++) wait_clk(1);
    wait_clk(5);
    lat = fe_cycle - t_fall;
    check("timeout/fired", fe_cnt - fe0, 1);
    check("timeout/latency_in_window", (lat >= TIMEOUT && lat <= TIMEOUT + 40), 1'b1);
    check("timeout/keyValid", kv_cnt - kv0, 0);
    check("timeout/cur", curPressed, m_cur);
    m_brk = 1'b0;
    m_ext = 1'b0;
    frame_and_check(8'h2D, 1'b0, "after_timeout_2D");

    // Short low glitches with data low would start a frame if they got through.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    ps2Data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ps2Clk = 1'b0;
      wait_clk(5);
      ps2Clk = 1'b1;
      wait_clk(20);
    end
    ps2Data = 1'b1;
    wait_clk(20);
    check("glitch/keyValid", kv_cnt - kv0, 0);
    check("glitch/frameErr", fe_cnt - fe0, 0);
    check("glitch/cur", curPressed, m_cur);
    frame_and_check(8'h4B, 1'b0, "after_glitch_4B");

    send_frame(8'h3C, 1'b0, 7);
    resetN = 1'b0;
    wait_clk(3);
    check("midreset/cur", curPressed, 8'h00);
    check("midreset/keyValid", keyValid, 1'b0);
    check("midreset/frameErr", frameErr, 1'b0);
    m_cur = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    resetN = 1'b1;
    wait_clk(20);
    frame_and_check(8'h1C, 1'b0, "after_reset_1C");

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit         bad;
      b   = pool[$urandom_range(7)];
      bad = ($urandom_range(7) == 0);
      frame_and_check(b, bad, $sformatf("rand%0d_%02h", i, b));
    end

    check("pulses_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
